lda_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares the single line-drawing circuit among several line requesters, such as the visualizer bar renderers. It owns the line circuit's Go/Done handshake and holds the coordinates and colour stable for the whole draw. It returns a per-requester completion pulse. It sits between the requesters and the line circuit; the line circuit's Draw/Write_Finish path to the memory controller is untouched.

---
 rtl/lda_sched_pkg.sv | 33 +++
 rtl/lda_scheduler_rr_arbiter.sv | 33 +++
 rtl/lda_scheduler.sv | 150 +++++++++++++++
 tb/tb_lda_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lda_sched_pkg.sv
// Shared types and constants for the line-draw scheduler.
// Optional range clipping is compiled in with LDA_SCHED_CLIP_EN.
package lda_sched_pkg;

    localparam int unsigned XW       = 9;
    localparam int unsigned YW       = 8;
    localparam int unsigned CW       = 16;
    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        COOLDOWN
    } state_e;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y0;
        logic [YW-1:0] y1;
        logic [CW-1:0] color;
    } line_cmd_t;

    // True when every endpoint lies on the visible screen.
    function automatic logic cmd_in_range(input line_cmd_t c);
        return (c.x0 < XW'(SCREEN_W)) && (c.x1 < XW'(SCREEN_W)) &&
               (c.y0 < YW'(SCREEN_H)) && (c.y1 < YW'(SCREEN_H));
    endfunction

endpackage

// File: rtl/lda_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate so ptr lands on bit 0, then take the lowest set bit.
    always_comb begin
        rot = {req, req} >> ptr;
        off = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                off = IW'(k);
            end
        end
        sum = (IW+1)'(ptr) + (IW+1)'(off);
        idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/lda_scheduler.sv
// Round-robin sequencer sharing one line-drawing circuit among N_REQ requesters.
// Define LDA_SCHED_CLIP_EN to reject off-screen commands in IDLE with ack+err.
module lda_scheduler
    import lda_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N_REQ-1:0]      req,
    input  logic [XW*N_REQ-1:0]   req_x0,
    input  logic [XW*N_REQ-1:0]   req_x1,
    input  logic [YW*N_REQ-1:0]   req_y0,
    input  logic [YW*N_REQ-1:0]   req_y1,
    input  logic [CW*N_REQ-1:0]   req_color,
    output logic [N_REQ-1:0]      ack,
    output logic                  err,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic                  lda_go,
    output logic [XW-1:0]         lda_x0,
    output logic [XW-1:0]         lda_x1,
    output logic [YW-1:0]         lda_y0,
    output logic [YW-1:0]         lda_y1,
    output logic [CW-1:0]         lda_color,
    input  logic                  lda_done
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    line_cmd_t        cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             go_q, go_d;

    logic [N_REQ-1:0] ack_c;
    logic             err_c;
    logic             reject_c;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;
    line_cmd_t        cmds [N_REQ];
    line_cmd_t        sel_cmd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_REQ - 1)) ? '0 : p + PW'(1);
    endfunction

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cmds[i] = '{x0:    req_x0[i*XW +: XW],
                        x1:    req_x1[i*XW +: XW],
                        y0:    req_y0[i*YW +: YW],
                        y1:    req_y1[i*YW +: YW],
                        color: req_color[i*CW +: CW]};
        end
    end

    assign sel_cmd = cmds[arb_idx];

`ifdef LDA_SCHED_CLIP_EN
    assign reject_c = resetn && arb_any && !cmd_in_range(sel_cmd);
`else
    assign reject_c = 1'b0;
`endif

    // Next-state; ack/err are combinational so they land on the Done/reject cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        ack_c   = '0;
        err_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reject_c) begin
                    ack_c = arb_gnt;
                    err_c = 1'b1;
                    ptr_d = ptr_inc(arb_idx);
                end else if (arb_any) begin
                    cmd_d   = sel_cmd;
                    grant_d = arb_gnt;
                    win_d   = arb_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE:      state_d = WAIT_START;
            WAIT_START: if (!lda_done) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (lda_done) begin
                    ack_c   = grant_q;
                    ptr_d   = ptr_inc(win_q);
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        go_d   = (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
        end
    end

    assign ack       = ack_c;
    assign err       = err_c;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign lda_go    = go_q;
    assign lda_x0    = cmd_q.x0;
    assign lda_x1    = cmd_q.x1;
    assign lda_y0    = cmd_q.y0;
    assign lda_y1    = cmd_q.y1;
    assign lda_color = cmd_q.color;

endmodule

// File: tb/tb_lda_scheduler.sv
// Randomized scoreboard bench for lda_scheduler with a behavioural line-circuit model.
module tb_lda_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [9*N-1:0] req_x0, req_x1;
    logic [8*N-1:0] req_y0, req_y1;
    logic [16*N-1:0] req_color;
    logic [N-1:0]   ack, grant;
    logic           err, busy, lda_go, lda_done;
    logic [8:0]     lda_x0, lda_x1;
    logic [7:0]     lda_y0, lda_y1;
    logic [15:0]    lda_color;

    lda_scheduler #(.N_REQ(N)) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .req_color(req_color), .ack(ack), .err(err), .grant(grant), .busy(busy),
        .lda_go(lda_go), .lda_x0(lda_x0), .lda_x1(lda_x1), .lda_y0(lda_y0),
        .lda_y1(lda_y1), .lda_color(lda_color), .lda_done(lda_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        bit          reject;
        logic [49:0] cmd;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   open;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]  tx0 [N], tx1 [N];
    logic [7:0]  ty0 [N], ty1 [N];
    logic [15:0] tcol[N];
    int m_ptr;
    int req_cyc;
    int force_len;
    bit mischief_en, force_drop;

    int remain, rise_cyc;
    bit in_done, rise_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [49:0] pack_cmd(input int i);
        return {tx0[i], tx1[i], ty0[i], ty1[i], tcol[i]};
    endfunction

    function automatic bit out_of_range(input int i);
`ifdef LDA_SCHED_CLIP_EN
        return (tx0[i] > 9'd319) || (tx1[i] > 9'd319) || (ty0[i] > 8'd239) || (ty1[i] > 8'd239);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_x0[i*9 +: 9]     = tx0[i];
            req_x1[i*9 +: 9]     = tx1[i];
            req_y0[i*8 +: 8]     = ty0[i];
            req_y1[i*8 +: 8]     = ty1[i];
            req_color[i*16 +: 16] = tcol[i];
        end
    endtask

    task automatic rand_cmd(input int i, input bit on_screen);
        tx0[i]  = on_screen ? 9'($urandom_range(0, 319)) : 9'($urandom_range(0, 511));
        tx1[i]  = on_screen ? 9'($urandom_range(0, 319)) : 9'($urandom_range(0, 511));
        ty0[i]  = on_screen ? 8'($urandom_range(0, 239)) : 8'($urandom_range(0, 255));
        ty1[i]  = on_screen ? 8'($urandom_range(0, 239)) : 8'($urandom_range(0, 255));
        tcol[i] = 16'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            tx1[i] = tx0[i];
            ty1[i] = ty0[i];
        end
    endtask

    // Reference arbitration: pending set served in order ptr, ptr+1, ... wrapping.
    task automatic push_expected(input logic [N-1:0] mask, output int pend);
        int last;
        exp_t e;
        last = -1;
        pend = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (mask[i]) begin
                e.idx = i;
                e.reject = out_of_range(i);
                e.cmd = pack_cmd(i);
                exp_q.push_back(e);
                last = i;
                pend++;
            end
        end
        if (last >= 0) m_ptr = (last + 1) % N;
    endtask

    task automatic raise(input logic [N-1:0] mask);
        @(posedge clk);
        #1;
        req = req | mask;
        drive();
        req_cyc = cyc;
    endtask

    // Requester behaviour: drop req on ack; optionally misbehave while granted.
    task automatic wait_done(input int pend_in, output int first_lat, output int n_go);
        int pend, guard;
        logic [N-1:0] a, g;
        logic bsy;
        bit mis[N];
        pend = pend_in;
        guard = 0;
        n_go = 0;
        first_lat = -1;
        bsy = 1'b1;
        for (int i = 0; i < N; i++) mis[i] = 1'b0;
        while ((pend > 0 || bsy) && guard < 3000) begin
            @(negedge clk);
            a = ack;
            g = grant;
            bsy = busy;
            if (lda_go) begin
                n_go++;
                if (first_lat < 0) first_lat = cyc - req_cyc + 1;
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (a[i]) begin
                    pend--;
                    req[i] = 1'b0;
                end
                if (mischief_en && g[i] && !mis[i]) begin
                    mis[i] = 1'b1;
                    rand_cmd(i, 1'b0);
                    if (force_drop || $urandom_range(0, 1) == 1) req[i] = 1'b0;
                end
            end
            drive();
            guard++;
        end
        chk("batch_outstanding_acks", 64'(pend), 64'(0));
        chk("batch_queue_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic batch(input logic [N-1:0] mask, output int first_lat, output int n_go);
        int p;
        push_expected(mask, p);
        raise(mask);
        wait_done(p, first_lat, n_go);
    endtask

    // Line circuit: Done drops the cycle after Go, stays low a few cycles,
    // then one done-state cycle where a Go would be lost.
    initial begin
        bit gs;
        lda_done = 1'b1;
        remain = 0;
        in_done = 1'b0;
        rise_valid = 1'b0;
        forever begin
            @(negedge clk);
            gs = lda_go;
            @(posedge clk);
            #1;
            if (!resetn) begin
                lda_done = 1'b1;
                remain = 0;
                in_done = 1'b0;
                rise_valid = 1'b0;
            end else begin
                if (gs) chk("go_while_line_busy", 64'(remain > 0 || in_done), 64'(0));
                if (in_done) begin
                    in_done = 1'b0;
                end else if (remain > 0) begin
                    remain--;
                    if (remain == 0) begin
                        lda_done = 1'b1;
                        in_done = 1'b1;
                        rise_cyc = cyc;
                        rise_valid = 1'b1;
                    end
                end else if (gs) begin
                    lda_done = 1'b0;
                    remain = (force_len > 0) ? force_len : $urandom_range(1, 5);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every Go or rejection and checks acks.
    initial begin
        exp_t e;
        open = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                open = 1'b0;
            end else begin
                if (lda_go) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_go", 64'(lda_go), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("go_vs_reject", 64'(lda_go), 64'(!e.reject));
                        chk("go_grant", 64'(grant), 64'(oh(e.idx)));
                        chk("go_cmd", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_color}), 64'(e.cmd));
                        if (rise_valid) begin
                            n_cmp++;
                            if (cyc - rise_cyc < 3) begin
                                n_bad++;
                                $display("FAIL done_to_go_gap: got %0d cycles, required >= 3", cyc - rise_cyc);
                            end
                        end
                        cur = e;
                        open = 1'b1;
                    end
                end else if (busy && open) begin
                    chk("cmd_stable", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_color}), 64'(cur.cmd));
                    chk("grant_stable", 64'(grant), 64'(oh(cur.idx)));
                end
                if (err && ack == '0) chk("err_without_ack", 64'(err), 64'(0));
                if (ack != '0) begin
                    if (err) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_reject", 64'(ack), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("reject_expected", 64'(err), 64'(e.reject));
                            chk("reject_ack", 64'(ack), 64'(oh(e.idx)));
                        end
                    end else if (!open) begin
                        chk("stray_ack", 64'(ack), 64'(0));
                    end else begin
                        chk("done_ack", 64'(ack), 64'(oh(cur.idx)));
                        open = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int lat, gos, p, exp_go;
        resetn = 1'b0;
        req = '0;
        m_ptr = 0;
        force_len = 0;
        mischief_en = 1'b0;
        force_drop = 1'b0;
        for (int i = 0; i < N; i++) begin
            tx0[i] = '0; tx1[i] = '0; ty0[i] = '0; ty1[i] = '0; tcol[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_go", 64'(lda_go), 64'(0));
        chk("rst_cmd", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_color}), 64'(0));
        resetn = 1'b1;

        // Single directed request on requester 1
        tx0[1] = 9'd10; tx1[1] = 9'd100; ty0[1] = 8'd20; ty1[1] = 8'd50; tcol[1] = 16'hF800;
        batch(4'b0010, lat, gos);
        chk("go_latency", 64'(lat), 64'(2));

        // All four continuously requesting, with misbehaving granted requesters
        mischief_en = 1'b1;
        repeat (3) begin
            for (int i = 0; i < N; i++) rand_cmd(i, 1'b1);
            batch(4'b1111, lat, gos);
            chk("all_four_go_count", 64'(gos), 64'(4));
        end

        // Requester 2 drops req and changes coordinates mid-draw
        force_drop = 1'b1;
        rand_cmd(2, 1'b1);
        batch(4'b0100, lat, gos);
        force_drop = 1'b0;

        // Degenerate single-pixel lines
        for (int i = 0; i < N; i++) begin
            rand_cmd(i, 1'b1);
            tx1[i] = tx0[i];
            ty1[i] = ty0[i];
        end
        batch(4'b1111, lat, gos);

        // Random masks and coordinates (some off-screen)
        repeat (25) begin
            for (int i = 0; i < N; i++) rand_cmd(i, $urandom_range(0, 1) == 1);
            batch(4'($urandom_range(1, 15)), lat, gos);
        end
        mischief_en = 1'b0;

        // x1 just past the right edge
        rand_cmd(0, 1'b1);
        tx1[0] = 9'd320;
        batch(4'b0001, lat, gos);
`ifdef LDA_SCHED_CLIP_EN
        exp_go = 0;
`else
        exp_go = 1;
`endif
        chk("clip_go_count", 64'(gos), 64'(exp_go));

        // Reset during WAIT_DONE
        force_len = 8;
        for (int i = 0; i < N; i++) rand_cmd(i, 1'b1);
        push_expected(4'b1111, p);
        raise(4'b1111);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lda_go) break;
        end
        chk("rst_test_go_seen", 64'(lda_go), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        force_len = 0;
        #1;
        chk("midrst_ack", 64'(ack), 64'(0));
        chk("midrst_err", 64'(err), 64'(0));
        chk("midrst_grant", 64'(grant), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_go", 64'(lda_go), 64'(0));
        chk("midrst_cmd", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_color}), 64'(0));
        exp_q.delete();
        m_ptr = 0;
        repeat (3) @(posedge clk);
        push_expected(req, p);
        #1;
        resetn = 1'b1;
        wait_done(p, lat, gos);
        chk("post_reset_go_count", 64'(gos), 64'(4));

        // A final random batch after reset
        for (int i = 0; i < N; i++) rand_cmd(i, 1'b1);
        batch(4'b1011, lat, gos);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
